c2_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one C2-style logic cell datapath among NREQ requesters.
- Each requester presents four data words (D00, D01, D10, D11) and four select bits (A1, B1, A0, B0).
- The block grants one requester, registers its operands and evaluates the cell function. It then returns the result with a valid/ready handshake.
- Sits between the requesting logic blocks and the shared cell in the logic-design/FPGA-synthesis datapath.

---
 rtl/c2_share_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_c2_share_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/c2_share_arbiter.sv
// c2_share_arbiter
//   Round-robin arbiter and sequencer that shares one C2-style logic cell
//   among NREQ requesters. One requester is granted, its operands are
//   registered and the cell result is returned over a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request, held until that requester's gnt bit
//   d00_bus    D00 operand of requester i at [i*XLEN +: XLEN]
//   d01_bus    D01 operand, same packing
//   d10_bus    D10 operand, same packing
//   d11_bus    D11 operand, same packing
//   sel_bus    selects of requester i at [i*4 +: 4], packed {A1,B1,A0,B0}
//   gnt        one-hot grant, one cycle wide (during EXEC)
//   res        registered cell result
//   res_id     index of the requester that produced res
//   res_valid  res/res_id valid
//   res_ready  consumer accepts result (only looked at in RESP)
//   busy       high whenever the FSM is not IDLE
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | sample req, pick round-robin winner, latch its operands
// EXEC   | gnt[win_id] high, cell evaluated on the registered operands
// RESP   | result held with res_valid until res_ready
module c2_share_arbiter #(
  parameter int XLEN = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XLEN-1:0] d00_bus,
  input  logic [NREQ*XLEN-1:0] d01_bus,
  input  logic [NREQ*XLEN-1:0] d10_bus,
  input  logic [NREQ*XLEN-1:0] d11_bus,
  input  logic [NREQ*4-1:0]    sel_bus,
  output logic [NREQ-1:0]      gnt,
  output logic [XLEN-1:0]      res,
  output logic [IDW-1:0]       res_id,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_win_id;
  logic [XLEN-1:0] r_d00;
  logic [XLEN-1:0] r_d01;
  logic [XLEN-1:0] r_d10;
  logic [XLEN-1:0] r_d11;
  logic [3:0]      r_sel;
  logic [XLEN-1:0] r_res;
  logic [IDW-1:0]  r_res_id;
  logic            r_res_valid;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [IDW:0]    w_idx;
  logic            w_s0;
  logic            w_s1;
  logic [XLEN-1:0] w_cell;
  logic [IDW-1:0]  w_ptr_nxt;

  // Search ptr, ptr+1, ... wrapping mod NREQ; the first set req wins.
  // One extra bit holds ptr+k before the wrap correction.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && req[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  // Cell: S0 = A0 & B0, S1 = A1 | B1; {S1,S0} picks the data word.
  assign w_s0 = r_sel[1] & r_sel[0];
  assign w_s1 = r_sel[3] | r_sel[2];

  always_comb begin
    w_cell = r_d00;
    case ({w_s1, w_s0})
      2'b00:   w_cell = r_d00;
      2'b01:   w_cell = r_d01;
      2'b10:   w_cell = r_d10;
      default: w_cell = r_d11;
    endcase
  end

  assign w_ptr_nxt = (r_win_id == IDW'(NREQ-1)) ? '0 : r_win_id + 1'b1;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. gnt decodes straight from state so reset clears it at once.
  always_comb begin
    gnt  = '0;
    busy = (r_state != S_IDLE);
    if (r_state == S_EXEC) begin
      gnt[r_win_id] = 1'b1;
    end
  end

  // Operand capture, result and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_win_id    <= '0;
      r_d00       <= '0;
      r_d01       <= '0;
      r_d10       <= '0;
      r_d11       <= '0;
      r_sel       <= '0;
      r_res       <= '0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win_id <= w_win;
            r_d00    <= d00_bus[w_win*XLEN +: XLEN];
            r_d01    <= d01_bus[w_win*XLEN +: XLEN];
            r_d10    <= d10_bus[w_win*XLEN +: XLEN];
            r_d11    <= d11_bus[w_win*XLEN +: XLEN];
            r_sel    <= sel_bus[w_win*4 +: 4];
          end
        end
        S_EXEC: begin
          r_res       <= w_cell;
          r_res_id    <= r_win_id;
          r_res_valid <= 1'b1;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            // Pointer only moves on acceptance, which bounds the wait of
            // any continuously requesting index to NREQ transactions.
            r_ptr       <= w_ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign res       = r_res;
  assign res_id    = r_res_id;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_c2_share_arbiter.sv
module tb_c2_share_arbiter;

  localparam int XLEN = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*XLEN-1:0] d00_bus;
  logic [NREQ*XLEN-1:0] d01_bus;
  logic [NREQ*XLEN-1:0] d10_bus;
  logic [NREQ*XLEN-1:0] d11_bus;
  logic [NREQ*4-1:0]    sel_bus;
  logic [NREQ-1:0]      gnt;
  logic [XLEN-1:0]      res;
  logic [IDW-1:0]       res_id;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  c2_share_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d00_bus   (d00_bus),
    .d01_bus   (d01_bus),
    .d10_bus   (d10_bus),
    .d11_bus   (d11_bus),
    .sel_bus   (sel_bus),
    .gnt       (gnt),
    .res       (res),
    .res_id    (res_id),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] sel;
    logic [3:0]  gnt;
    logic [7:0]  res;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic [7:0] hold_res;

    // Requester data: index 1 carries the 0x11/0x22/0x33/0x44 set,
    // the others use distinct high nibbles so a wrong winner is visible.
    d00_bus = {8'hE0, 8'hC0, 8'h11, 8'hA0};
    d01_bus = {8'hE1, 8'hC1, 8'h22, 8'hA1};
    d10_bus = {8'hE2, 8'hC2, 8'h33, 8'hA2};
    d11_bus = {8'hE3, 8'hC3, 8'h44, 8'hA3};
    sel_bus = '0;
    req = '0;
    res_ready = 1'b0;
    rst_n = 1'b0;

    // Expected pointer after each row noted on the right.
    vecs[0] = '{4'b0010, 16'h0030, 4'b0010, 8'h22, 2'd1}; // ptr 2
    vecs[1] = '{4'b0010, 16'h0000, 4'b0010, 8'h11, 2'd1}; // ptr 2
    vecs[2] = '{4'b0010, 16'h0060, 4'b0010, 8'h33, 2'd1}; // ptr 2
    vecs[3] = '{4'b0010, 16'h00B0, 4'b0010, 8'h44, 2'd1}; // ptr 2
    vecs[4] = '{4'b0001, 16'h0000, 4'b0001, 8'hA0, 2'd0}; // ptr 1
    vecs[5] = '{4'b1101, 16'h0C00, 4'b0100, 8'hC2, 2'd2}; // ptr 3
    vecs[6] = '{4'b1001, 16'h3000, 4'b1000, 8'hE1, 2'd3}; // ptr 0
    vecs[7] = '{4'b1001, 16'h000F, 4'b0001, 8'hA3, 2'd0}; // ptr 1
    vecs[8] = '{4'b0001, 16'h0001, 4'b0001, 8'hA0, 2'd0}; // ptr 1
    vecs[9] = '{4'b1000, 16'h8000, 4'b1000, 8'hE2, 2'd3}; // ptr 0

    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_res", 32'(res), 32'h0);
    chk("rst_res_id", 32'(res_id), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single transactions from the table.
    for (int i = 0; i < 10; i++) begin
      sel_bus   = vecs[i].sel;
      req       = vecs[i].req;
      res_ready = 1'b0;
      tick();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      chk($sformatf("v%0d_valid_exec", i), 32'(res_valid), 32'h0);
      req = '0;
      tick();
      chk($sformatf("v%0d_gnt_off", i), 32'(gnt), 32'h0);
      chk($sformatf("v%0d_valid", i), 32'(res_valid), 32'h1);
      chk($sformatf("v%0d_res", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("v%0d_res_id", i), 32'(res_id), 32'(vecs[i].id));
      res_ready = 1'b1;
      tick();
      chk($sformatf("v%0d_valid_off", i), 32'(res_valid), 32'h0);
      chk($sformatf("v%0d_busy_off", i), 32'(busy), 32'h0);
      res_ready = 1'b0;
    end

    // All requesting, consumer always ready: 0,1,2,3,0 every 3 cycles.
    req = 4'b1111;
    res_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (gnt == '0 && cnt < 10);
      chk($sformatf("rr%0d_gnt", n), 32'(gnt), 32'(4'b0001 << (n % 4)));
      if (n == 0) chk("rr0_latency", cnt, 1);
      else chk($sformatf("rr%0d_spacing", n), cnt, 3);
    end
    req = '0;
    tick();
    tick();  // accepted, ptr 1

    // Stall in RESP with everyone requesting.
    sel_bus = 16'h0030;
    res_ready = 1'b0;
    req = 4'b1111;
    tick();
    chk("stall_gnt", 32'(gnt), 32'h2);
    tick();
    chk("stall_res", 32'(res), 32'h22);
    hold_res = res;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall%0d_valid", c), 32'(res_valid), 32'h1);
      chk($sformatf("stall%0d_res", c), 32'(res), 32'(hold_res));
      chk($sformatf("stall%0d_id", c), 32'(res_id), 32'h1);
      chk($sformatf("stall%0d_gnt", c), 32'(gnt), 32'h0);
    end
    res_ready = 1'b1;
    tick();
    chk("stall_release_valid", 32'(res_valid), 32'h0);
    tick();
    chk("stall_next_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    tick();  // accepted, ptr 3
    res_ready = 1'b0;

    // Asynchronous reset while holding a result in RESP.
    d01_bus[2*XLEN +: XLEN] = 8'h5A;
    sel_bus = 16'h0300;
    req = 4'b0100;
    tick();
    chk("ar_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    chk("ar_res_before", 32'(res), 32'h5A);
    chk("ar_valid_before", 32'(res_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_res", 32'(res), 32'h0);
    chk("ar_res_id", 32'(res_id), 32'h0);
    chk("ar_valid", 32'(res_valid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // ptr was 3 before reset; reset must bring it back to 0.
    req = 4'b1001;
    tick();
    chk("ar_post_gnt", 32'(gnt), 32'h1);
    req = '0;
    res_ready = 1'b1;
    tick();
    chk("ar_post_res", 32'(res), 32'hA0);
    tick();
    chk("ar_post_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
